// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared encodings and constants for the unified-RAM port arbiter.
//            Optional feature macro used by this slice: ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Transaction owner identifiers
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Width of the RAM data bus (one doubleword)
  localparam int REG_BUS = 64;

  // Default RAM read latency in cycles
  localparam int RAM_LAT_DEFAULT = 1;

  // Latency counter width; holds RAM_LAT-1 for RAM_LAT up to 15
  localparam int CNT_W = 4;

  // Pick the 32-bit instruction word out of a RAM doubleword
  function automatic logic [31:0] word_select(input logic [REG_BUS-1:0] dword,
                                              input logic               upper);
    return upper ? dword[63:32] : dword[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_arb_pick
// Brief    : Combinational winner select between the fetch and load/store
//            requesters. Fixed MEM-over-IF priority by default; round-robin
//            against the previous grant when ARB_RR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   mem_req,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant_owner
);

`ifndef ARB_RR_EN
  // Fixed priority never looks at the grant history
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Winner select; a lone requester always wins, contention resolved below
  always_comb begin
    grant_valid = if_req | mem_req;
    grant_owner = OWN_IF;
`ifdef ARB_RR_EN
    if (if_req && mem_req) begin
      grant_owner = (last_grant == OWN_MEM) ? OWN_IF : OWN_MEM;
    end else if (mem_req) begin
      grant_owner = OWN_MEM;
    end
`else
    if (mem_req) begin
      grant_owner = OWN_MEM;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port unified RAM between instruction fetch and
//            load/store. One transaction outstanding at a time: the winner is
//            granted combinationally in IDLE, the RAM latency is counted out
//            in BUSY, and the response is steered back to the owner.
//            Optional feature macro: ARB_RR_EN (round-robin arbitration).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RAM_LAT = RAM_LAT_DEFAULT,  // legal range 1..15
  parameter int ADDR_W  = REG_BUS
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // load/store requester
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_wdata,
  input  logic [7:0]        mem_wmask,
  output logic              mem_ready,
  output logic              mem_rvalid,
  output logic [63:0]       mem_rdata,
  // RAM side
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [63:0]       ram_wdata,
  output logic [7:0]        ram_wmask,
  input  logic [63:0]       ram_rdata
);

  // Counter reload: response lands RAM_LAT cycles after the grant cycle
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT - 1);

  arb_state_e       state_q;
  owner_e           owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             addr2_q;   // fetch word select within the doubleword
  logic             store_q;   // owner was a store: ack carries zero data

  logic             pick_valid;
  owner_e           pick_owner;
  owner_e           last_grant_sel;
  logic             grant_fire;
  logic             resp_fire;

  // Only word-aligned fetch and doubleword-aligned RAM addresses matter
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], mem_addr[2:0]};

`ifdef ARB_RR_EN
  owner_e last_grant_q;

  // Remember who won most recently so contention alternates
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= OWN_IF;
    end else if (grant_fire) begin
      last_grant_q <= pick_owner;
    end
  end

  assign last_grant_sel = last_grant_q;
`else
  assign last_grant_sel = OWN_IF;
`endif

  mem_port_arbiter_arb_pick u_arb_pick (
    .if_req      (if_req),
    .mem_req     (mem_req),
    .last_grant  (last_grant_sel),
    .grant_valid (pick_valid),
    .grant_owner (pick_owner)
  );

  // Outputs stay quiet while reset is held, even if a requester is waiting
  assign grant_fire = (state_q == ARB_IDLE) && pick_valid && !rst;
  assign resp_fire  = (state_q == ARB_BUSY) && (cnt_q == '0) && !rst;

  // Sequencer: accept one winner in IDLE, count out the RAM latency in BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
      addr2_q <= 1'b0;
      store_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            state_q <= ARB_BUSY;
            owner_q <= pick_owner;
            cnt_q   <= CNT_LOAD;
            addr2_q <= if_addr[2];
            store_q <= (pick_owner == OWN_MEM) && mem_we;
          end
        end
        ARB_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= ARB_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // Grant-cycle RAM drive and owner-steered response; everything else is 0
  always_comb begin
    if_ready   = 1'b0;
    mem_ready  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_wmask  = '0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    if (grant_fire) begin
      ram_en = 1'b1;
      if (pick_owner == OWN_MEM) begin
        mem_ready = 1'b1;
        ram_we    = mem_we;
        ram_addr  = {mem_addr[ADDR_W-1:3], 3'b000};
        ram_wdata = mem_wdata;
        ram_wmask = mem_wmask;
      end else begin
        if_ready  = 1'b1;
        ram_addr  = {if_addr[ADDR_W-1:3], 3'b000};
      end
    end

    if (resp_fire) begin
      if (owner_q == OWN_MEM) begin
        mem_rvalid = 1'b1;
        mem_rdata  = store_q ? 64'h0 : ram_rdata;
      end else begin
        if_rvalid  = 1'b1;
        if_rdata   = word_select(ram_rdata, addr2_q);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter. Two instances
//            (RAM_LAT=1 and RAM_LAT=3) share one clock. Table vectors, hand
//            sequences for multi-cycle corners, then randomized traffic
//            against a transaction-level model. Honours ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [NI];
  logic        if_req     [NI];
  logic [63:0] if_addr    [NI];
  logic        if_ready   [NI];
  logic        if_rvalid  [NI];
  logic [31:0] if_rdata   [NI];
  logic        mem_req    [NI];
  logic        mem_we     [NI];
  logic [63:0] mem_addr   [NI];
  logic [63:0] mem_wdata  [NI];
  logic [7:0]  mem_wmask  [NI];
  logic        mem_ready  [NI];
  logic        mem_rvalid [NI];
  logic [63:0] mem_rdata  [NI];
  logic        ram_en     [NI];
  logic        ram_we     [NI];
  logic [63:0] ram_addr   [NI];
  logic [63:0] ram_wdata  [NI];
  logic [7:0]  ram_wmask  [NI];
  logic [63:0] ram_rdata  [NI];

  mem_port_arbiter #(.RAM_LAT(1), .ADDR_W(64)) dut_lat1 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wmask(mem_wmask[0]), .mem_ready(mem_ready[0]),
    .mem_rvalid(mem_rvalid[0]), .mem_rdata(mem_rdata[0]),
    .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_wmask(ram_wmask[0]), .ram_rdata(ram_rdata[0])
  );

  mem_port_arbiter #(.RAM_LAT(3), .ADDR_W(64)) dut_lat3 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wmask(mem_wmask[1]), .mem_ready(mem_ready[1]),
    .mem_rvalid(mem_rvalid[1]), .mem_rdata(mem_rdata[1]),
    .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_wmask(ram_wmask[1]), .ram_rdata(ram_rdata[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Phase helpers: drive just after the rising edge, sample at the falling edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_idle(input int k);
    rst[k] = 1'b0;       if_req[k] = 1'b0;     if_addr[k] = '0;
    mem_req[k] = 1'b0;   mem_we[k] = 1'b0;     mem_addr[k] = '0;
    mem_wdata[k] = '0;   mem_wmask[k] = '0;    ram_rdata[k] = '0;
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    nxt();
    rst[k] = 1'b0;
  endtask

  // ---------------- table vectors (RAM_LAT=1 instance) ----------------
  typedef struct {
    logic        if_req;
    logic [63:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        e_if_ready;
    logic        e_mem_ready;
    logic        e_ram_we;
    logic [63:0] e_ram_addr;
    logic [7:0]  e_wmask;
    logic        e_if_rvalid;
    logic        e_mem_rvalid;
    logic [31:0] e_if_rdata;
    logic [63:0] e_mem_rdata;
  } vec_t;

  vec_t vt [7];

  // ---------------- transaction-level model storage ----------------
  typedef struct {
    int          due;
    bit          is_mem;
    logic [63:0] data;
  } resp_t;

  resp_t       exp_q [$];
  logic [63:0] env_mem [logic [63:0]];
  logic [63:0] mdl_mem [logic [63:0]];

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] env_rd(input logic [63:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_val(a);
  endfunction

  function automatic logic [63:0] mdl_rd(input logic [63:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
  endfunction

  // Random traffic: a RAM behaves per the latency contract; the model predicts
  // every grant and response purely from arbitration rules and cycle arithmetic
  task automatic run_random(input int k, input int ncyc);
    int          lat, next_free, env_due;
    bit          if_pend, mem_pend, r, g_if, g_mem, last_mem, rv_if, rv_mem;
    logic [63:0] ia, ma, mwd, key, d, ed, env_key;
    logic        mwe;
    logic [7:0]  mwm;
    resp_t       e;
    lat = (k == 0) ? 1 : 3;
    env_mem.delete(); mdl_mem.delete(); exp_q.delete();
    if_pend = 0; mem_pend = 0; next_free = 0; env_due = -1; last_mem = 0;
    ia = 64'h8000_0000; ma = 64'h8000_0000; mwd = '0; mwe = 1'b0; mwm = '0;
    env_key = '0; key = '0;
    set_idle(k);
    do_reset(k);
    for (int c = 0; c < ncyc; c++) begin
      r = ($urandom_range(0, 63) == 0);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; ia = 64'h8000_0000 + 64'($urandom_range(0, 255));
      end else if (if_pend && $urandom_range(0, 49) == 0) begin
        if_pend = 0;
      end
      if (!mem_pend && $urandom_range(0, 2) == 0) begin
        mem_pend = 1; ma = 64'h8000_0000 + 64'($urandom_range(0, 255));
        mwe = 1'($urandom_range(0, 1)); mwd = {$urandom, $urandom};
        mwm = 8'($urandom_range(0, 255));
      end else if (mem_pend && $urandom_range(0, 49) == 0) begin
        mem_pend = 0;
      end
      rst[k] = r;
      if_req[k] = if_pend;   if_addr[k] = if_pend ? ia : {$urandom, $urandom};
      mem_req[k] = mem_pend; mem_we[k] = mwe; mem_addr[k] = ma;
      mem_wdata[k] = mwd;    mem_wmask[k] = mwm;
      ram_rdata[k] = (c == env_due) ? env_rd(env_key) : {$urandom, $urandom};

      g_if = 0; g_mem = 0;
      if (r) begin
        exp_q.delete(); next_free = c + 1; last_mem = 0;
      end else if (c >= next_free && (if_pend || mem_pend)) begin
        if (if_pend && mem_pend) begin
`ifdef ARB_RR_EN
          g_mem = !last_mem;
`else
          g_mem = 1;
`endif
        end else begin
          g_mem = mem_pend;
        end
        g_if = !g_mem;
        last_mem = g_mem;
        next_free = c + lat + 1;
        key = (g_mem ? ma : ia) & ~64'h7;
        d = mdl_rd(key);
        if (g_mem && mwe) begin
          mdl_mem[key] = merge(d, mwd, mwm);
          e.data = '0;
        end else if (g_mem) begin
          e.data = d;
        end else begin
          e.data = {32'h0, ia[2] ? d[63:32] : d[31:0]};
        end
        e.due = c + lat; e.is_mem = g_mem;
        exp_q.push_back(e);
      end

      smp();
      if (!r) begin
        chk("rnd_if_ready", if_ready[k], g_if);
        chk("rnd_mem_ready", mem_ready[k], g_mem);
        chk("rnd_ram_en", ram_en[k], g_if | g_mem);
        if (g_if || g_mem) begin
          chk("rnd_ram_addr", ram_addr[k], key);
          chk("rnd_ram_we", ram_we[k], g_mem && mwe);
          if (g_mem && mwe) begin
            chk("rnd_ram_wdata", ram_wdata[k], mwd);
            chk("rnd_ram_wmask", ram_wmask[k], mwm);
          end
        end
        rv_if = 0; rv_mem = 0; ed = '0;
        if (exp_q.size() > 0) begin
          if (exp_q[0].due == c) begin
            rv_if = !exp_q[0].is_mem; rv_mem = exp_q[0].is_mem; ed = exp_q[0].data;
            void'(exp_q.pop_front());
          end
        end
        chk("rnd_if_rvalid", if_rvalid[k], rv_if);
        chk("rnd_mem_rvalid", mem_rvalid[k], rv_mem);
        if (rv_if) chk("rnd_if_rdata", if_rdata[k], ed);
        if (rv_mem) chk("rnd_mem_rdata", mem_rdata[k], ed);
      end
      if (ram_en[k]) begin
        if (ram_we[k]) env_mem[ram_addr[k]] = merge(env_rd(ram_addr[k]), ram_wdata[k], ram_wmask[k]);
        env_key = ram_addr[k];
        env_due = c + lat;
      end
      if (g_if) if_pend = 0;
      if (g_mem) mem_pend = 0;
      nxt();
    end
    set_idle(k);
  endtask

  initial begin
    bit exp_mem;

    //                 if   if_addr             mem  we   mem_addr            wdata               wmask  rdata
    //                 e_ifr e_memr e_we e_ram_addr        e_wm  e_ifv e_memv e_if_rdata   e_mem_rdata
    vt[0] = '{1'b1, 64'h8000_0004, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h1111_2222_3333_4444,
              1'b1, 1'b0, 1'b0, 64'h8000_0000, 8'h00, 1'b1, 1'b0, 32'h1111_2222, 64'h0};
    vt[1] = '{1'b1, 64'h8000_0010, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD,
              1'b1, 1'b0, 1'b0, 64'h8000_0010, 8'h00, 1'b1, 1'b0, 32'hCCCC_DDDD, 64'h0};
    vt[2] = '{1'b1, 64'h8000_000F, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h7654_3210_0F0F_0F0F,
              1'b1, 1'b0, 1'b0, 64'h8000_0008, 8'h00, 1'b1, 1'b0, 32'h7654_3210, 64'h0};
    vt[3] = '{1'b1, 64'h8000_0020, 1'b1, 1'b0, 64'h8000_1008, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF,
              1'b0, 1'b1, 1'b0, 64'h8000_1008, 8'h00, 1'b0, 1'b1, 32'h0, 64'h0123_4567_89AB_CDEF};
    vt[4] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h8000_2004, 64'h0000_0000_DEAD_BEEF, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF,
              1'b0, 1'b1, 1'b1, 64'h8000_2000, 8'h0F, 1'b0, 1'b1, 32'h0, 64'h0};
    vt[5] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0007, 64'h0, 8'h00, 64'hFEDC_BA98_7654_3210,
              1'b0, 1'b1, 1'b0, 64'h8000_0000, 8'h00, 1'b0, 1'b1, 32'h0, 64'hFEDC_BA98_7654_3210};
    vt[6] = '{1'b0, 64'h8000_0100, 1'b0, 1'b0, 64'h8000_0200, 64'h0, 8'h00, 64'h1234_5678_9ABC_DEF0,
              1'b0, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 32'h0, 64'h0};

    for (int k = 0; k < NI; k++) begin
      set_idle(k);
      rst[k] = 1'b1;
    end
    nxt();
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;

    // Reset state: nothing asserted with no requests pending
    smp();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset%0d_if_ready", k), if_ready[k], 0);
      chk($sformatf("reset%0d_mem_ready", k), mem_ready[k], 0);
      chk($sformatf("reset%0d_ram_en", k), ram_en[k], 0);
      chk($sformatf("reset%0d_ram_we", k), ram_we[k], 0);
      chk($sformatf("reset%0d_ram_addr", k), ram_addr[k], 0);
      chk($sformatf("reset%0d_if_rvalid", k), if_rvalid[k], 0);
      chk($sformatf("reset%0d_mem_rvalid", k), mem_rvalid[k], 0);
    end
    nxt();

    // Table: one full RAM_LAT=1 transaction per vector
    for (int i = 0; i < 7; i++) begin
      if_req[0] = vt[i].if_req;   if_addr[0] = vt[i].if_addr;
      mem_req[0] = vt[i].mem_req; mem_we[0] = vt[i].mem_we; mem_addr[0] = vt[i].mem_addr;
      mem_wdata[0] = vt[i].wdata; mem_wmask[0] = vt[i].wmask;
      ram_rdata[0] = 64'hBAD0_BAD0_BAD0_BAD0;
      smp();
      chk($sformatf("v%0d_if_ready", i), if_ready[0], vt[i].e_if_ready);
      chk($sformatf("v%0d_mem_ready", i), mem_ready[0], vt[i].e_mem_ready);
      chk($sformatf("v%0d_ram_en", i), ram_en[0], vt[i].e_if_ready | vt[i].e_mem_ready);
      chk($sformatf("v%0d_ram_we", i), ram_we[0], vt[i].e_ram_we);
      chk($sformatf("v%0d_ram_addr", i), ram_addr[0], vt[i].e_ram_addr);
      if (vt[i].e_ram_we) begin
        chk($sformatf("v%0d_ram_wdata", i), ram_wdata[0], vt[i].wdata);
        chk($sformatf("v%0d_ram_wmask", i), ram_wmask[0], vt[i].e_wmask);
      end
      nxt();
      if_req[0] = 1'b0; mem_req[0] = 1'b0;
      ram_rdata[0] = vt[i].rdata;
      smp();
      chk($sformatf("v%0d_if_rvalid", i), if_rvalid[0], vt[i].e_if_rvalid);
      chk($sformatf("v%0d_mem_rvalid", i), mem_rvalid[0], vt[i].e_mem_rvalid);
      if (vt[i].e_if_rvalid) chk($sformatf("v%0d_if_rdata", i), if_rdata[0], vt[i].e_if_rdata);
      if (vt[i].e_mem_rvalid) chk($sformatf("v%0d_mem_rdata", i), mem_rdata[0], vt[i].e_mem_rdata);
      nxt();
    end

    // Both requesting (LAT=1): MEM first, IF waits and wins at T+2
    do_reset(0);
    if_req[0] = 1'b1;  if_addr[0] = 64'h8000_0020;
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 64'h8000_1008;
    smp();
    chk("both_T_mem_ready", mem_ready[0], 1);
    chk("both_T_if_ready", if_ready[0], 0);
    nxt();
    mem_req[0] = 1'b0; ram_rdata[0] = 64'h0123_4567_89AB_CDEF;
    smp();
    chk("both_T1_mem_rvalid", mem_rvalid[0], 1);
    chk("both_T1_mem_rdata", mem_rdata[0], 64'h0123_4567_89AB_CDEF);
    chk("both_T1_if_ready", if_ready[0], 0);
    chk("both_T1_if_rvalid", if_rvalid[0], 0);
    nxt();
    smp();
    chk("both_T2_if_ready", if_ready[0], 1);
    chk("both_T2_ram_addr", ram_addr[0], 64'h8000_0020);
    nxt();
    if_req[0] = 1'b0; ram_rdata[0] = 64'h9999_8888_7777_6666;
    smp();
    chk("both_T3_if_rvalid", if_rvalid[0], 1);
    chk("both_T3_if_rdata", if_rdata[0], 32'h7777_6666);
    nxt();

    // LAT=3: response exactly at T+3, readies held low while IF keeps asking
    do_reset(1);
    mem_req[1] = 1'b1; mem_we[1] = 1'b0; mem_addr[1] = 64'h8000_0100;
    if_req[1] = 1'b1;  if_addr[1] = 64'h8000_0104;
    smp();
    chk("lat3_T_mem_ready", mem_ready[1], 1);
    chk("lat3_T_if_ready", if_ready[1], 0);
    nxt();
    mem_req[1] = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      ram_rdata[1] = (t == 3) ? 64'hA5A5_5A5A_0000_FFFF : 64'hDEAD_0000_0000_0000;
      smp();
      chk($sformatf("lat3_T%0d_if_ready", t), if_ready[1], 0);
      chk($sformatf("lat3_T%0d_mem_ready", t), mem_ready[1], 0);
      chk($sformatf("lat3_T%0d_mem_rvalid", t), mem_rvalid[1], (t == 3));
      chk($sformatf("lat3_T%0d_if_rvalid", t), if_rvalid[1], 0);
      if (t == 3) chk("lat3_T3_mem_rdata", mem_rdata[1], 64'hA5A5_5A5A_0000_FFFF);
      nxt();
    end
    smp();
    chk("lat3_T4_if_ready", if_ready[1], 1);
    nxt();
    if_req[1] = 1'b0;
    for (int t = 5; t <= 7; t++) begin
      ram_rdata[1] = (t == 7) ? 64'hCAFE_F00D_1234_5678 : 64'h0;
      smp();
      chk($sformatf("lat3_T%0d_if_rvalid", t), if_rvalid[1], (t == 7));
      if (t == 7) chk("lat3_T7_if_rdata", if_rdata[1], 32'hCAFE_F00D);
      nxt();
    end

    // LAT=3: reset at T+1 aborts the read; new request accepted at T+2
    do_reset(1);
    if_req[1] = 1'b1; if_addr[1] = 64'h8000_0200;
    smp();
    chk("abort_T_if_ready", if_ready[1], 1);
    nxt();
    if_req[1] = 1'b0; rst[1] = 1'b1;
    nxt();
    rst[1] = 1'b0;
    mem_req[1] = 1'b1; mem_we[1] = 1'b0; mem_addr[1] = 64'h8000_0300;
    smp();
    chk("abort_T2_mem_ready", mem_ready[1], 1);
    chk("abort_T2_ram_addr", ram_addr[1], 64'h8000_0300);
    nxt();
    mem_req[1] = 1'b0; ram_rdata[1] = 64'h5555_5555_5555_5555;
    smp();
    chk("abort_T3_if_rvalid", if_rvalid[1], 0);
    chk("abort_T3_mem_rvalid", mem_rvalid[1], 0);
    nxt();
    smp();
    chk("abort_T4_mem_rvalid", mem_rvalid[1], 0);
    nxt();
    ram_rdata[1] = 64'h0BAD_F00D_0BAD_F00D;
    smp();
    chk("abort_T5_mem_rvalid", mem_rvalid[1], 1);
    chk("abort_T5_mem_rdata", mem_rdata[1], 64'h0BAD_F00D_0BAD_F00D);
    nxt();
    set_idle(1);

    // Sustained contention (LAT=1): grant order over four grants
    do_reset(0);
    if_req[0] = 1'b1;  if_addr[0] = 64'h8000_0040;
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 64'h8000_0048;
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_RR_EN
      exp_mem = (g % 2 == 0);
`else
      exp_mem = 1'b1;
`endif
      smp();
      chk($sformatf("arb_g%0d_mem_ready", g), mem_ready[0], exp_mem);
      chk($sformatf("arb_g%0d_if_ready", g), if_ready[0], !exp_mem);
      nxt();
      ram_rdata[0] = 64'h0000_0001_0000_0002;
      smp();
      chk($sformatf("arb_g%0d_mem_rvalid", g), mem_rvalid[0], exp_mem);
      chk($sformatf("arb_g%0d_if_rvalid", g), if_rvalid[0], !exp_mem);
      nxt();
    end
    set_idle(0);

    run_random(0, 400);
    run_random(1, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
